// File: rtl/mem_access_pkg.sv
// Shared encodings for the byte-serial load/store unit: access sizes, FSM states
// and the size-to-byte-count helper.
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BEAT,
      ST_RESP
   } state_t;

   // Illegal size falls into the default; it never reaches a beat.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of an assembled load value according to access size.
module mem_load_extend
   import mem_access_pkg::*;
(
   input  logic        [1:0]  size,
   input  logic               unsign,
   input  logic        [31:0] raw,
   output logic signed [31:0] ext
);

   logic signed [7:0]  raw_b;
   logic signed [15:0] raw_h;

   always_comb begin
      raw_b = raw[7:0];
      raw_h = raw[15:0];
      ext   = raw;
      case (size)
         SZ_BYTE: ext = unsign ? {24'h0, raw[7:0]}  : 32'(raw_b);
         SZ_HALF: ext = unsign ? {16'h0, raw[15:0]} : 32'(raw_h);
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, executed as single-byte memory
// beats, with load assembly/extension and store byte slicing.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsign,
   input  logic [7:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        by,
   output logic        half,
   output logic        unsign,
   output logic [7:0]  addr,
   output logic [31:0] data_in,
   input  logic [31:0] data_out
);

   state_t state, state_nxt;

   logic [1:0]  cnt;
   logic        wr_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [7:0]  base_q;
   logic [31:0] wdata_q;
   logic [2:0]  n_q;
   logic        err_q;
   logic [31:0] asm_q;
   logic signed [31:0] ext_data;

   logic accept;
   logic misaligned;
   logic req_bad;
   logic last_beat;
   logic data_out_unused;

   // Memory returns a zero-extended byte; only the low lane carries data.
   assign data_out_unused = ^data_out[31:8];

   assign accept     = req_valid && (state == ST_IDLE);
   assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
   assign req_bad    = (req_size == 2'b11) || (!ALLOW_MISALIGNED && misaligned);
   assign last_beat  = ({1'b0, cnt} == (n_q - 3'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= 2'd0;
         else if (state == ST_BEAT)
            cnt <= cnt + 2'd1;
      end
   end

   // Request fields and load assembly carry no reset; they are only observed
   // in states reached after an accept has loaded them.
   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q    <= req_write;
         size_q  <= req_size;
         uns_q   <= req_unsign;
         base_q  <= req_addr;
         wdata_q <= req_wdata;
         n_q     <= size_bytes(req_size);
         err_q   <= req_bad;
         asm_q   <= 32'h0;
      end else if ((state == ST_BEAT) && !wr_q) begin
         asm_q[{cnt, 3'b000} +: 8] <= data_out[7:0];
      end
   end

   mem_load_extend u_extend (
      .size   (size_q),
      .unsign (uns_q),
      .raw    (asm_q),
      .ext    (ext_data)
   );

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'h0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      by         = 1'b0;
      half       = 1'b0;
      unsign     = 1'b0;
      addr       = 8'h0;
      data_in    = 32'h0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_nxt = req_bad ? ST_RESP : ST_BEAT;
         end
         ST_BEAT: begin
            MemRead  = !wr_q;
            MemWrite = wr_q;
            by       = 1'b1;
            unsign   = 1'b1;
            addr     = base_q + {6'b0, cnt};
            if (wr_q)
               data_in = {24'h0, wdata_q[{cnt, 3'b000} +: 8]};
            if (last_beat)
               state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (err_q || wr_q) ? 32'h0 : ext_data;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: strict-alignment and misaligned-allowed instances
// share a byte-wide memory model; responses are checked against a scoreboard.
module tb_mem_access_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sel;
   logic        req_valid, req_write, req_unsign;
   logic [1:0]  req_size;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [31:0] data_out;

   logic        rdy0, rv0, er0, mr0, mw0, by0, hf0, us0;
   logic        rdy1, rv1, er1, mr1, mw1, by1, hf1, us1;
   logic [31:0] rd0, rd1, di0, di1;
   logic [7:0]  ad0, ad1;

   logic        v0, v1;
   assign v0 = req_valid & ~sel;
   assign v1 = req_valid &  sel;

   mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_write(req_write),
      .req_size(req_size), .req_unsign(req_unsign), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0), .MemRead(mr0), .MemWrite(mw0),
      .by(by0), .half(hf0), .unsign(us0), .addr(ad0), .data_in(di0), .data_out(data_out)
   );

   mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
      .req_size(req_size), .req_unsign(req_unsign), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1), .MemRead(mr1), .MemWrite(mw1),
      .by(by1), .half(hf1), .unsign(us1), .addr(ad1), .data_in(di1), .data_out(data_out)
   );

   logic        req_ready, resp_valid, resp_err, m_read, m_write, m_by, m_half;
   logic [31:0] resp_rdata, m_din;
   logic [7:0]  m_addr;
   assign req_ready  = sel ? rdy1 : rdy0;
   assign resp_valid = sel ? rv1  : rv0;
   assign resp_err   = sel ? er1  : er0;
   assign resp_rdata = sel ? rd1  : rd0;
   assign m_read     = sel ? mr1  : mr0;
   assign m_write    = sel ? mw1  : mw0;
   assign m_by       = sel ? by1  : by0;
   assign m_half     = sel ? hf1  : hf0;
   assign m_addr     = sel ? ad1  : ad0;
   assign m_din      = sel ? di1  : di0;

   // Byte-wide data memory: combinational read, write at the rising edge.
   logic [7:0] mem [256];
   logic       mem_clr;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[100] <= 8'h11;
      end else if (m_write) begin
         mem[m_addr] <= m_din[7:0];
      end
   end
   assign data_out = m_read ? {24'h0, mem[m_addr]} : 32'h0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];
   exp_t ex;

   int n_checks = 0;
   int n_pass   = 0;

   int          cyc, rd_cnt, wr_cnt, by_cnt, n_addr;
   logic [7:0]  obs_addr [8];
   logic [31:0] got_rd;
   logic        got_er;

   // Drives one request starting now (caller is at a falling edge); returns
   // just after the accepting rising edge.
   task automatic send(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] e_rd, input logic e_er, input bit push);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_unsign = u;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (push) sb.push_back('{rdata: e_rd, err: e_er});
   endtask

   // Observes cycles after accept until resp_valid (bounded); cyc=-1 on timeout.
   task automatic wait_resp();
      cyc = 0; rd_cnt = 0; wr_cnt = 0; by_cnt = 0; n_addr = 0;
      got_rd = 32'h0; got_er = 1'b0;
      for (int k = 0; k < 8; k++) obs_addr[k] = 8'h00;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (resp_valid) begin
            got_rd = resp_rdata;
            got_er = resp_err;
            return;
         end
         if (m_read)  rd_cnt++;
         if (m_write) wr_cnt++;
         if (m_by && !m_half) by_cnt++;
         if ((m_read || m_write) && n_addr < 8) begin
            obs_addr[n_addr] = m_addr;
            n_addr++;
         end
      end
      cyc = -1;
   endtask

   task automatic test_reset();
      sel = 1'b0; rst = 1'b0; mem_clr = 1'b1; req_valid = 1'b0;
      req_write = 1'b0; req_size = 2'b00; req_unsign = 1'b0; req_addr = 8'h0; req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
      n_checks++;
      if ({resp_valid, resp_err, m_read, m_write, m_by, m_addr, m_din, resp_rdata} !== '0)
         $display("FAIL reset_outputs: got rv=%b mr=%b mw=%b addr=%h din=%h rd=%h want all 0",
                  resp_valid, m_read, m_write, m_addr, m_din, resp_rdata);
      else n_pass++;
      rst = 1'b1; mem_clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_word_load();
      sel = 1'b0;
      @(negedge clk);
      send(1'b0, 2'b10, 1'b0, 8'd100, 32'h0, 32'h0000_0011, 1'b0, 1'b1);
      wait_resp();
      ex = sb.pop_front();
      n_checks++;
      if (cyc !== 5) $display("FAIL word_load_latency: got %0d want 5", cyc); else n_pass++;
      n_checks++;
      if (rd_cnt !== 4 || by_cnt !== 4 || wr_cnt !== 0)
         $display("FAIL word_load_strobes: got rd=%0d by=%0d wr=%0d want 4 4 0", rd_cnt, by_cnt, wr_cnt);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs_addr[k] !== 8'(100 + k))
            $display("FAIL word_load_addr%0d: got %0d want %0d", k, obs_addr[k], 100 + k);
         else n_pass++;
      end
      n_checks++;
      if (got_rd !== ex.rdata || got_er !== ex.err)
         $display("FAIL word_load_resp: got %h/%b want %h/%b", got_rd, got_er, ex.rdata, ex.err);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0)
         $display("FAIL word_load_after: got rdy=%b rv=%b rd=%h want 1 0 0", req_ready, resp_valid, resp_rdata);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] want [2];
      sel = 1'b0;
      @(negedge clk);
      send(1'b1, 2'b10, 1'b0, 8'd200, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
      wait_resp();
      ex = sb.pop_front();
      n_checks++;
      if (cyc !== 5 || wr_cnt !== 4 || rd_cnt !== 0)
         $display("FAIL store_word_beats: got cyc=%0d wr=%0d rd=%0d want 5 4 0", cyc, wr_cnt, rd_cnt);
      else n_pass++;
      n_checks++;
      if (got_rd !== ex.rdata || got_er !== ex.err)
         $display("FAIL store_word_resp: got %h/%b want %h/%b", got_rd, got_er, ex.rdata, ex.err);
      else n_pass++;
      n_checks++;
      if ({mem[203], mem[202], mem[201], mem[200]} !== 32'hDEAD_BEEF)
         $display("FAIL store_word_mem: got %h want deadbeef", {mem[203], mem[202], mem[201], mem[200]});
      else n_pass++;
      want[0] = 32'hFFFF_DEAD;
      want[1] = 32'h0000_DEAD;
      for (int u = 0; u < 2; u++) begin
         // Issue in the cycle req_ready returns: one request per N+2 cycles.
         @(negedge clk);
         n_checks++;
         if (req_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", u, req_ready); else n_pass++;
         send(1'b0, 2'b01, u[0], 8'd202, 32'h0, want[u], 1'b0, 1'b1);
         wait_resp();
         ex = sb.pop_front();
         n_checks++;
         if (cyc !== 3 || got_rd !== ex.rdata || got_er !== ex.err)
            $display("FAIL half_load_u%0d: got cyc=%0d %h/%b want 3 %h/%b", u, cyc, got_rd, got_er, ex.rdata, ex.err);
         else n_pass++;
      end
   endtask

   task automatic test_byte();
      logic [31:0] want [2];
      sel = 1'b0;
      @(negedge clk);
      send(1'b1, 2'b00, 1'b0, 8'd150, 32'hAAAA_AA80, 32'h0, 1'b0, 1'b1);
      wait_resp();
      ex = sb.pop_front();
      n_checks++;
      if (cyc !== 2 || mem[150] !== 8'h80 || mem[151] !== 8'h00 || got_rd !== ex.rdata)
         $display("FAIL store_byte: got cyc=%0d m150=%h m151=%h rd=%h want 2 80 00 %h",
                  cyc, mem[150], mem[151], got_rd, ex.rdata);
      else n_pass++;
      want[0] = 32'hFFFF_FF80;
      want[1] = 32'h0000_0080;
      for (int u = 0; u < 2; u++) begin
         @(negedge clk);
         send(1'b0, 2'b00, u[0], 8'd150, 32'h0, want[u], 1'b0, 1'b1);
         wait_resp();
         ex = sb.pop_front();
         n_checks++;
         if (cyc !== 2 || got_rd !== ex.rdata || got_er !== ex.err)
            $display("FAIL byte_load_u%0d: got cyc=%0d %h/%b want 2 %h/%b", u, cyc, got_rd, got_er, ex.rdata, ex.err);
         else n_pass++;
      end
   endtask

   task automatic test_errors();
      logic [1:0] sz [3];
      logic [7:0] ad [3];
      logic       wr [3];
      sz[0] = 2'b10; ad[0] = 8'd101; wr[0] = 1'b0;
      sz[1] = 2'b11; ad[1] = 8'd0;   wr[1] = 1'b1;
      sz[2] = 2'b01; ad[2] = 8'd201; wr[2] = 1'b0;
      sel = 1'b0;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         send(wr[t], sz[t], 1'b0, ad[t], 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
         wait_resp();
         ex = sb.pop_front();
         n_checks++;
         if (cyc !== 1 || rd_cnt !== 0 || wr_cnt !== 0)
            $display("FAIL err%0d_timing: got cyc=%0d rd=%0d wr=%0d want 1 0 0", t, cyc, rd_cnt, wr_cnt);
         else n_pass++;
         n_checks++;
         if (got_rd !== ex.rdata || got_er !== ex.err)
            $display("FAIL err%0d_resp: got %h/%b want %h/%b", t, got_rd, got_er, ex.rdata, ex.err);
         else n_pass++;
      end
      n_checks++;
      if (mem[0] !== 8'h00) $display("FAIL err_no_write: got mem0=%h want 00", mem[0]); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [7:0] want_a [4];
      want_a[0] = 8'd254; want_a[1] = 8'd255; want_a[2] = 8'd0; want_a[3] = 8'd1;
      sel = 1'b1;
      @(negedge clk);
      send(1'b1, 2'b10, 1'b0, 8'd254, 32'h4433_2211, 32'h0, 1'b0, 1'b1);
      wait_resp();
      ex = sb.pop_front();
      n_checks++;
      if (cyc !== 5 || wr_cnt !== 4 || got_er !== ex.err || got_rd !== ex.rdata)
         $display("FAIL wrap_store: got cyc=%0d wr=%0d err=%b rd=%h want 5 4 0 0", cyc, wr_cnt, got_er, got_rd);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs_addr[k] !== want_a[k])
            $display("FAIL wrap_addr%0d: got %0d want %0d", k, obs_addr[k], want_a[k]);
         else n_pass++;
      end
      n_checks++;
      if ({mem[1], mem[0], mem[255], mem[254]} !== 32'h4433_2211)
         $display("FAIL wrap_mem: got %h want 44332211", {mem[1], mem[0], mem[255], mem[254]});
      else n_pass++;
      @(negedge clk);
      send(1'b0, 2'b01, 1'b0, 8'd255, 32'h0, 32'h0000_3322, 1'b0, 1'b1);
      wait_resp();
      ex = sb.pop_front();
      n_checks++;
      if (cyc !== 3 || got_rd !== ex.rdata || got_er !== ex.err)
         $display("FAIL misaligned_half: got cyc=%0d %h/%b want 3 %h/%b", cyc, got_rd, got_er, ex.rdata, ex.err);
      else n_pass++;
      sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      sel = 1'b0;
      @(negedge clk);
      send(1'b1, 2'b10, 1'b0, 8'd40, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (m_write !== 1'b1 || m_addr !== 8'd42)
         $display("FAIL rst_mid_beat2: got mw=%b addr=%0d want 1 42", m_write, m_addr);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || {m_read, m_write, m_by, m_addr, m_din, resp_valid, resp_rdata} !== '0)
         $display("FAIL rst_mid_async: got rdy=%b mw=%b addr=%h din=%h rv=%b want 1 0 0 0 0",
                  req_ready, m_write, m_addr, m_din, resp_valid);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({mem[43], mem[42], mem[41], mem[40]} !== 32'h0000_5678)
         $display("FAIL rst_mid_mem: got %h want 00005678", {mem[43], mem[42], mem[41], mem[40]});
      else n_pass++;
      rst = 1'b1;
      send(1'b0, 2'b00, 1'b0, 8'd40, 32'h0, 32'h0000_0078, 1'b0, 1'b1);
      wait_resp();
      ex = sb.pop_front();
      n_checks++;
      if (cyc !== 2 || got_rd !== ex.rdata || got_er !== ex.err)
         $display("FAIL rst_mid_first_req: got cyc=%0d %h/%b want 2 %h/%b", cyc, got_rd, got_er, ex.rdata, ex.err);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_word_load();
      test_back_to_back();
      test_byte();
      test_errors();
      test_wrap();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the core's execute stage and the byte-wide data memory port. It accepts one load or store request at a time over a valid/ready handshake and performs it as a sequence of single-byte memory accesses, one per clock. For loads it assembles and sign- or zero-extends the result; for stores it slices the write data into byte lanes. It drives MemRead/MemWrite/by/half/unsign/addr/data_in into the data memory and consumes its combinational data_out.

## Interface
- ALLOW_MISALIGNED, 0: when 0, a half not 2-aligned or a word not 4-aligned returns an error without touching memory; when 1, it proceeds byte-serially.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsign  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  8  byte address.
- req_wdata  in  32  store data; bytes taken from the low end.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: illegal size or disallowed misalignment.
- MemRead, MemWrite  out  1 each  memory strobes.
- by, half, unsign  out  1 each  memory access size controls.
- addr  out  8  memory byte address.
- data_in  out  32  memory write data.
- data_out  in  32  memory read data, valid combinationally in the same cycle.

## Operation
- FSM states:
  - IDLE: req_ready=1. On accept, latch write/size/unsign/addr/wdata and set N = 1/2/4. If the size is illegal, or the access is misaligned with ALLOW_MISALIGNED=0, set the error flag and go to RESP. Otherwise clear cnt and go to BEAT.
  - BEAT: each cycle performs byte cnt.
    - Memory controls: addr = base+cnt (8-bit, wraps 255→0), by=1, half=0, unsign=1.
    - Store: MemWrite=1, data_in = {24'h0, byte cnt of wdata}. The memory writes at the closing edge.
    - Load: MemRead=1. data_out[7:0] is captured into assembly byte cnt at the closing edge.
    - cnt==N-1 → RESP; otherwise cnt+1.
  - RESP: resp_valid=1 for one cycle, with resp_err and resp_rdata. Then IDLE.
- Load extension:
  - byte: signed ⇒ replicate bit 7 into [31:8], unsigned ⇒ zeros.
  - half: replicate bit 15 or zeros into [31:16].
  - word: unchanged.
- Outside BEAT, MemRead, MemWrite, by, half, unsign, addr and data_in are all 0.
- Memory-side outputs decode only from internal registers; there is no combinational path from req_* to the memory port.
- req_* is ignored when req_ready=0.
- Reset (any state, including mid-BEAT):
  - All outputs go to 0 immediately, except req_ready, which goes to 1; FSM returns to IDLE.
  - Bytes already written stay written; there is no rollback.

## Timing
- Accept at edge T. Beats occupy cycles T+1..T+N. resp_valid is high in cycle T+N+1. req_ready is next high in cycle T+N+2.
- Error path: resp_valid with resp_err=1 in cycle T+1, with no memory strobe at all.
- Throughput: one request per N+2 cycles.
- resp_rdata is stable throughout the RESP cycle and returns to 0 afterwards.

## Structure
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum ST_IDLE, ST_BEAT, ST_RESP;
  - byte-count function size→N.
- One combinational sub-module, mem_load_extend (size, unsign, 32-bit raw → 32-bit extended), instantiated on the assembly register.

## Test plan
- Word load at 100 after data memory reset (bytes 0x11,0,0,0): accept at T → addr 100,101,102,103 in T+1..T+4 with MemRead=1, by=1 → resp_valid at T+5, resp_rdata=0x00000011, resp_err=0.
- Word store 0xDEADBEEF at 200, then signed half load at 202: memory 200..203 = EF,BE,AD,DE → second resp_rdata=0xFFFFDEAD; the unsigned variant gives 0x0000DEAD.
- Signed byte load of stored 0x80 at 150 → 0xFFFFFF80; LBU → 0x00000080.
- ALLOW_MISALIGNED=0, word load at 101, and separately req_size=11 → resp_err=1 at T+1, MemRead/MemWrite never asserted, resp_rdata=0.
- ALLOW_MISALIGNED=1, word store 0x44332211 at 254 → bytes 11,22,33,44 at 254,255,0,1 (wrap), resp_valid at T+5.
- Store word at 40, rst low during beat index 2:
  - Outputs go to 0 asynchronously and req_ready goes to 1.
  - Only bytes 40,41 change.
  - After release, a new request is accepted on the first edge.
